// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle ALU controller: fetch operands, iterate shifts, write back results and flags
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   inst_valid/inst_ready/inst    instruction handshake; inst = {op[15:12], ra[11:9], rb[8:6], wb_b[5], -, count[3:0]}
//   rf_rd_addr_*/rf_rd_data_*     register-file read ports (combinational data)
//   rf_wr_en_*/addr_*/data_*      register-file write ports, driven during the write-back cycle
//   alu_inst/alu_a/alu_b/alu_*_in operands and flags presented to the ALU
//   alu_*_out                     ALU results, sampled once per execute cycle
//   flag_z/flag_n/flag_c          architectural status flags
//   busy, done                    busy outside IDLE; done pulses once after write-back
module alu_sequencer #(
    parameter int         REG_AW      = 3,
    parameter logic [2:0] ITER_PREFIX = 3'b100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [15:0]       inst,
    output logic [REG_AW-1:0] rf_rd_addr_a,
    output logic [REG_AW-1:0] rf_rd_addr_b,
    input  logic [15:0]       rf_rd_data_a,
    input  logic [15:0]       rf_rd_data_b,
    output logic              rf_wr_en_a,
    output logic              rf_wr_en_b,
    output logic [REG_AW-1:0] rf_wr_addr_a,
    output logic [REG_AW-1:0] rf_wr_addr_b,
    output logic [15:0]       rf_wr_data_a,
    output logic [15:0]       rf_wr_data_b,
    output logic [15:0]       alu_inst,
    output logic [15:0]       alu_a,
    output logic [15:0]       alu_b,
    output logic              alu_z_in,
    output logic              alu_n_in,
    output logic              alu_c_in,
    input  logic [15:0]       alu_a_out,
    input  logic [15:0]       alu_b_out,
    input  logic              alu_z_out,
    input  logic              alu_n_out,
    input  logic              alu_c_out,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t            state_q;
    logic [15:0]       inst_q;
    logic [15:0]       op_a_q;
    logic [15:0]       op_b_q;
    logic [3:0]        cnt_q;
    logic              wz_q, wn_q, wc_q;
    logic              flag_z_q, flag_n_q, flag_c_q;
    logic              inst_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              wr_en_a_q;
    logic              wr_en_b_q;

    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic              wb_b;
    logic              is_iter;
    logic [3:0]        cnt_d;
    logic              same_dest;

    assign ra        = REG_AW'(inst_q[11:9]);
    assign rb        = REG_AW'(inst_q[8:6]);
    assign wb_b      = inst_q[5];
    assign is_iter   = (inst_q[15:13] == ITER_PREFIX);
    // A zero shift count still performs one pass so every instruction touches the ALU.
    assign cnt_d     = !is_iter              ? 4'd1 :
                       (inst_q[3:0] == 4'd0) ? 4'd1 : inst_q[3:0];
    // Both writes to one register would collide; the B result takes priority.
    assign same_dest = wb_b && (ra == rb);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            inst_q       <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            cnt_q        <= '0;
            wz_q         <= 1'b0;
            wn_q         <= 1'b0;
            wc_q         <= 1'b0;
            flag_z_q     <= 1'b0;
            flag_n_q     <= 1'b0;
            flag_c_q     <= 1'b0;
            inst_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wr_en_a_q    <= 1'b0;
            wr_en_b_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (inst_valid && inst_ready_q) begin
                        inst_q       <= inst;
                        inst_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= S_READ;
                    end
                end
                S_READ: begin
                    op_a_q  <= rf_rd_data_a;
                    op_b_q  <= rf_rd_data_b;
                    cnt_q   <= cnt_d;
                    wz_q    <= flag_z_q;
                    wn_q    <= flag_n_q;
                    wc_q    <= flag_c_q;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    op_a_q <= alu_a_out;
                    op_b_q <= alu_b_out;
                    wz_q   <= alu_z_out;
                    wn_q   <= alu_n_out;
                    wc_q   <= alu_c_out;
                    cnt_q  <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        // Enables are registered so they are high exactly during WB.
                        wr_en_a_q <= !same_dest;
                        wr_en_b_q <= wb_b;
                        state_q   <= S_WB;
                    end
                end
                S_WB: begin
                    wr_en_a_q    <= 1'b0;
                    wr_en_b_q    <= 1'b0;
                    flag_z_q     <= wz_q;
                    flag_n_q     <= wn_q;
                    flag_c_q     <= wc_q;
                    done_q       <= 1'b1;
                    inst_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign inst_ready   = inst_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;

    assign rf_rd_addr_a = ra;
    assign rf_rd_addr_b = rb;

    assign rf_wr_en_a   = wr_en_a_q;
    assign rf_wr_en_b   = wr_en_b_q;
    assign rf_wr_addr_a = ra;
    assign rf_wr_addr_b = rb;
    assign rf_wr_data_a = op_a_q;
    assign rf_wr_data_b = op_b_q;

    assign alu_inst     = inst_q;
    assign alu_a        = op_a_q;
    assign alu_b        = op_b_q;
    assign alu_z_in     = wz_q;
    assign alu_n_in     = wn_q;
    assign alu_c_in     = wc_q;

    assign flag_z       = flag_z_q;
    assign flag_n       = flag_n_q;
    assign flag_c       = flag_c_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with register-file and ALU models
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [2:0]  rf_rd_addr_a, rf_rd_addr_b;
    logic [15:0] rf_rd_data_a, rf_rd_data_b;
    logic        rf_wr_en_a, rf_wr_en_b;
    logic [2:0]  rf_wr_addr_a, rf_wr_addr_b;
    logic [15:0] rf_wr_data_a, rf_wr_data_b;
    logic [15:0] alu_inst, alu_a, alu_b;
    logic        alu_z_in, alu_n_in, alu_c_in;
    logic [15:0] alu_a_out, alu_b_out;
    logic        alu_z_out, alu_n_out, alu_c_out;
    logic        flag_z, flag_n, flag_c;
    logic        busy, done;

    alu_sequencer dut (
        .clk(clk), .rst(rst),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .rf_wr_en_a(rf_wr_en_a), .rf_wr_en_b(rf_wr_en_b),
        .rf_wr_addr_a(rf_wr_addr_a), .rf_wr_addr_b(rf_wr_addr_b),
        .rf_wr_data_a(rf_wr_data_a), .rf_wr_data_b(rf_wr_data_b),
        .alu_inst(alu_inst), .alu_a(alu_a), .alu_b(alu_b),
        .alu_z_in(alu_z_in), .alu_n_in(alu_n_in), .alu_c_in(alu_c_in),
        .alu_a_out(alu_a_out), .alu_b_out(alu_b_out),
        .alu_z_out(alu_z_out), .alu_n_out(alu_n_out), .alu_c_out(alu_c_out),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Register file: combinational read, write at the clock edge (B after A).
    logic [15:0] rf [8];
    logic        pre_we = 1'b0;
    logic [2:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    assign rf_rd_data_a = rf[rf_rd_addr_a];
    assign rf_rd_data_b = rf[rf_rd_addr_b];

    always @(posedge clk) begin
        if (pre_we) begin
            rf[pre_addr] <= pre_data;
        end else begin
            if (rf_wr_en_a) rf[rf_wr_addr_a] <= rf_wr_data_a;
            if (rf_wr_en_b) rf[rf_wr_addr_b] <= rf_wr_data_b;
        end
    end

    // ALU: 4 add, 5 sub (C=borrow), 6 add-with-carry, 8 shl by 1, 9 shr by 1, others or.
    always_comb begin
        logic [16:0] s;
        s         = '0;
        alu_a_out = alu_a | alu_b;
        alu_b_out = alu_a ^ alu_b;
        alu_c_out = 1'b0;
        case (alu_inst[15:12])
            4'h4: begin s = {1'b0, alu_a} + {1'b0, alu_b}; alu_a_out = s[15:0]; alu_c_out = s[16]; end
            4'h5: begin alu_a_out = alu_a - alu_b; alu_c_out = (alu_a < alu_b); end
            4'h6: begin s = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_c_in}; alu_a_out = s[15:0]; alu_c_out = s[16]; end
            4'h8: begin alu_a_out = alu_a << 1; alu_c_out = alu_a[15]; alu_b_out = alu_b; end
            4'h9: begin alu_a_out = alu_a >> 1; alu_c_out = alu_a[0]; alu_b_out = alu_b; end
            default: ;
        endcase
        alu_z_out = (alu_a_out == 16'd0);
        alu_n_out = alu_a_out[15];
    end

    // Handshake monitor.
    int cyc = 0, acc_n = 0, done_n = 0;
    int acc_last = 0, acc_prev = 0, done_last = 0, done_prev = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (inst_valid && inst_ready) begin
            acc_n <= acc_n + 1; acc_prev <= acc_last; acc_last <= cyc;
        end
        if (done) begin
            done_n <= done_n + 1; done_prev <= done_last; done_last <= cyc;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issue one instruction; lat = negedges after the accept edge until done is seen.
    task automatic run_inst(input logic [15:0] ins, output int lat, output int wa,
                            output int wb, output int rdy_bad);
        int n;
        lat = -1; wa = 0; wb = 0; rdy_bad = 0;
        @(negedge clk);
        inst_valid = 1'b1; inst = ins;
        @(posedge clk);
        @(negedge clk);
        inst_valid = 1'b0;
        for (n = 0; n < 40; n++) begin
            if (done) begin lat = n; break; end
            if (inst_ready) rdy_bad++;
            if (rf_wr_en_a) wa++;
            if (rf_wr_en_b) wb++;
            @(negedge clk);
        end
        if (lat < 0) chk("done_timeout", 32'(n), 32'd0);
    endtask

    // Reference model: whole-instruction effect computed in one step.
    logic [15:0] mr [8];
    logic        mz, mn, mc;

    task automatic model_step(input logic [15:0] ins, output int k);
        logic [2:0]  ra, rb;
        logic [15:0] a, b, ares, bres;
        logic [16:0] s;
        logic        c;
        ra = ins[11:9]; rb = ins[8:6]; a = mr[ra]; b = mr[rb];
        k = 1; bres = a ^ b; c = 1'b0;
        if (ins[15:13] == 3'b100) begin
            k = (ins[3:0] == 4'd0) ? 1 : int'(ins[3:0]);
            bres = b;
            if (ins[12] == 1'b0) begin ares = a << k; c = a[16-k]; end
            else                 begin ares = a >> k; c = a[k-1];  end
        end else begin
            case (ins[15:12])
                4'h4: begin s = a + b; ares = s[15:0]; c = s[16]; end
                4'h5: begin ares = a - b; c = (a < b); end
                4'h6: begin s = a + b + mc; ares = s[15:0]; c = s[16]; end
                default: ares = a | b;
            endcase
        end
        if (ins[5]) mr[rb] = bres;
        if (!(ins[5] && ra == rb)) mr[ra] = ares;
        mz = (ares == 16'd0); mn = ares[15]; mc = c;
    endtask

    typedef struct {
        logic [15:0] ins;
        logic [15:0] va, vb;
        logic [15:0] era, erb;
        logic [2:0]  ezc;
        int          elat, ewa, ewb;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat, wa, wb, rb_bad, k, mism;
        logic [15:0] ins;

        vecs[0] = '{16'h4280, 16'd1,    16'd1, 16'd2,    16'd1, 3'b000, 3,  1, 0};
        vecs[1] = '{16'h5280, 16'd1,    16'd1, 16'd0,    16'd1, 3'b100, 3,  1, 0};
        vecs[2] = '{16'h9203, 16'h0010, 16'd0, 16'h0002, 16'd0, 3'b000, 5,  1, 0};
        vecs[3] = '{16'h9200, 16'd2,    16'd0, 16'd1,    16'd0, 3'b000, 3,  1, 0};
        vecs[4] = '{16'h42A0, 16'd3,    16'd4, 16'd7,    16'd7, 3'b000, 3,  1, 1};
        vecs[5] = '{16'h4260, 16'd3,    16'd3, 16'd0,    16'd0, 3'b000, 3,  0, 1};
        vecs[6] = '{16'h5280, 16'd1,    16'd2, 16'hFFFF, 16'd2, 3'b011, 3,  1, 0};
        vecs[7] = '{16'h8204, 16'h9000, 16'd0, 16'h0000, 16'd0, 3'b101, 6,  1, 0};
        vecs[8] = '{16'h820F, 16'd1,    16'd0, 16'h8000, 16'd0, 3'b010, 17, 1, 0};

        for (int i = 0; i < 8; i++) rf[i] = '0;
        rst = 1'b1; inst_valid = 1'b0; inst = '0;
        @(negedge clk);
        chk("rst_ready", inst_ready, 1);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_wren",  {rf_wr_en_a, rf_wr_en_b}, 0);
        chk("rst_flags", {flag_z, flag_n, flag_c}, 0);
        chk("rst_alu_inst", alu_inst, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            set_reg(vecs[i].ins[11:9], vecs[i].va);
            set_reg(vecs[i].ins[8:6],  vecs[i].vb);
            run_inst(vecs[i].ins, lat, wa, wb, rb_bad);
            chk($sformatf("v%0d_ra", i), rf[vecs[i].ins[11:9]], vecs[i].era);
            chk($sformatf("v%0d_rb", i), rf[vecs[i].ins[8:6]],  vecs[i].erb);
            chk($sformatf("v%0d_flags", i), {flag_z, flag_n, flag_c}, vecs[i].ezc);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].elat);
            chk($sformatf("v%0d_wr_a_cycles", i), wa, vecs[i].ewa);
            chk($sformatf("v%0d_wr_b_cycles", i), wb, vecs[i].ewb);
            chk($sformatf("v%0d_ready_low", i), rb_bad, 0);
        end

        // Reset during the 5th execute cycle of an 8-step shift.
        set_reg(3'd1, 16'd1); set_reg(3'd2, 16'd1);
        run_inst(16'h5280, lat, wa, wb, rb_bad);
        chk("pre_rst_z", flag_z, 1);
        set_reg(3'd1, 16'h1234);
        @(negedge clk);
        inst_valid = 1'b1; inst = 16'h8208;
        @(posedge clk);
        @(negedge clk);
        inst_valid = 1'b0;
        wa = 0;
        repeat (5) begin
            if (rf_wr_en_a || rf_wr_en_b) wa++;
            @(negedge clk);
        end
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_ready", inst_ready, 1);
        chk("arst_busy",  busy, 0);
        chk("arst_flags", {flag_z, flag_n, flag_c}, 0);
        if (rf_wr_en_a || rf_wr_en_b) wa++;
        @(negedge clk);
        if (rf_wr_en_a || rf_wr_en_b) wa++;
        rst = 1'b0;
        chk("arst_no_write", wa, 0);
        chk("arst_r1_kept", rf[1], 16'h1234);
        set_reg(3'd1, 16'd5); set_reg(3'd2, 16'd6);
        run_inst(16'h4280, lat, wa, wb, rb_bad);
        chk("post_rst_r1", rf[1], 16'd11);
        chk("post_rst_lat", lat, 3);

        // Back-to-back ADDs with inst_valid held high.
        set_reg(3'd1, 16'd1); set_reg(3'd2, 16'd1);
        begin
            int a0, d0;
            a0 = acc_n; d0 = done_n;
            @(negedge clk);
            inst_valid = 1'b1; inst = 16'h4280;
            for (int n = 0; n < 40 && acc_n < a0 + 2; n++) @(negedge clk);
            inst_valid = 1'b0;
            for (int n = 0; n < 40 && done_n < d0 + 2; n++) @(negedge clk);
            repeat (6) @(negedge clk);
            chk("b2b_accepts", acc_n - a0, 2);
            chk("b2b_dones", done_n - d0, 2);
            chk("b2b_gap", acc_last - acc_prev, 4);
            chk("b2b_after_done", acc_last, done_prev);
            chk("b2b_r1", rf[1], 16'd3);
        end

        // Randomized instructions against the reference model.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        mz = 0; mn = 0; mc = 0;
        for (int i = 0; i < 8; i++) begin
            mr[i] = 16'($urandom);
            if (i == 2) mr[i] = 16'd0;
            set_reg(3'(i), mr[i]);
        end
        for (int t = 0; t < 40; t++) begin
            ins = 16'($urandom);
            model_step(ins, k);
            run_inst(ins, lat, wa, wb, rb_bad);
            mism = 0;
            for (int i = 0; i < 8; i++) if (rf[i] !== mr[i]) mism++;
            chk($sformatf("rnd%0d_regs_%h", t, ins), mism, 0);
            chk($sformatf("rnd%0d_flags_%h", t, ins), {flag_z, flag_n, flag_c}, {mz, mn, mc});
            chk($sformatf("rnd%0d_lat_%h", t, ins), lat, 2 + k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller that owns the combinational ALU.
- Accepts one 16-bit instruction at a time over a valid/ready handshake, reads both operands from the register file and drives the ALU.
- Iterates shift-class opcodes once per count, then writes results and Z/N/C flags back.
- Sits between the instruction decoder and the register file/ALU pair; it is the only master of the ALU and of the program status flags.

Parameters:
- REG_AW, 3, register-file address width (8 registers).
- ITER_PREFIX, 3'b100, opcodes with inst[15:13]==ITER_PREFIX are iterative (shift left/right); all others execute in one ALU pass.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock, asynchronous, active-high.
- inst_valid  in  1  instruction offered.
- inst_ready  out  1  controller can accept an instruction.
- inst  in  16  instruction: [15:12] opcode, [11:9] ra, [8:6] rb, [5] wb_b, [3:0] count.
- rf_rd_addr_a  out  REG_AW  read port A address (= ra).
- rf_rd_addr_b  out  REG_AW  read port B address (= rb).
- rf_rd_data_a  in  16  combinational read data A.
- rf_rd_data_b  in  16  combinational read data B.
- rf_wr_en_a  out  1  write ALU A result to ra.
- rf_wr_en_b  out  1  write ALU B result to rb.
- rf_wr_addr_a  out  REG_AW  write address A.
- rf_wr_addr_b  out  REG_AW  write address B.
- rf_wr_data_a  out  16  write data A.
- rf_wr_data_b  out  16  write data B.
- alu_inst  out  16  instruction to ALU.
- alu_a, alu_b  out  16  ALU operand inputs.
- alu_z_in, alu_n_in, alu_c_in  out  1  ALU flag inputs.
- alu_a_out, alu_b_out  in  16  ALU results.
- alu_z_out, alu_n_out, alu_c_out  in  1  ALU flag outputs.
- flag_z, flag_n, flag_c  out  1  architectural status flags.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when write-back occurs.

Behaviour:
- States: IDLE, READ, EXEC, WB.
- Reset (asynchronous, any state):
  - state=IDLE; inst_ready=1; busy=0; done=0.
  - rf_wr_en_a/b=0; flags=000.
  - Latched inst, operands and iteration counter cleared; outputs derived from them read 0.
  - An in-flight instruction is discarded with no write-back.
- IDLE:
  - inst_ready=1.
  - On inst_valid & inst_ready at a clock edge: latch inst, go READ.
  - inst_valid without ready is ignored and never queued.
- READ (1 cycle):
  - rf_rd_addr_a/b = latched ra/rb.
  - Latch rf_rd_data_a/b into op_a/op_b.
  - Load iteration counter: count for iterative opcodes, with count==0 treated as 1; otherwise 1.
  - Load working flags from flag_z/n/c. Go EXEC.
- EXEC (1 cycle per iteration):
  - alu_inst=latched inst; alu_a=op_a; alu_b=op_b; alu_z/n/c_in=working flags.
  - Each edge: op_a<=alu_a_out, op_b<=alu_b_out, working flags<=alu flag outputs, counter-=1.
  - When the counter reaches 0, go WB.
  - Iterative ops take count (1..15) EXEC cycles; non-iterative ops take exactly 1.
- WB (1 cycle):
  - rf_wr_en_a=1 with rf_wr_addr_a=ra and rf_wr_data_a=op_a.
  - rf_wr_en_b=wb_b with rf_wr_addr_b=rb and rf_wr_data_b=op_b.
  - If ra==rb and both writes are enabled, only the B write is driven and the A enable is suppressed.
  - flag_z/n/c<=working flags at the WB edge.
  - done=1. Go IDLE.
- Latency: if accepted at edge T, done is high during the cycle after edge T+2+k, where k = EXEC cycles. Next accept is possible at edge T+3+k.
- ALU outputs hold their last values outside EXEC; the ALU is only sampled in EXEC.
- The register-file write lands at the WB edge. Because READ of the next instruction is at least 2 cycles later, there is no forwarding path.
- flags change only at WB, never mid-iteration.

Test Plan:
- ADD (inst=0x4280, r1=1, r2=1) -> r1=2, flags Z0 N0 C0, done pulses at the 3rd edge after accept, inst_ready low in between.
- SUB (inst=0x5280, r1=1, r2=1) -> r1=0, flag_z=1, flag_n=0, r2 not written.
- Shift right (inst=0x9203, r1=0x0010) -> 3 EXEC cycles, r1=0x0002, done at edge T+5. With count=0 (inst=0x9200, r1=2) -> exactly 1 iteration, r1=1.
- wb_b set (inst=0x42A0, r1=3, r2=4) -> both rf_wr_en_a and rf_wr_en_b high for the single WB cycle with ALU A/B results. With ra==rb (inst=0x4260, r1=3) -> only the B write is driven.
- Assert rst during the 5th EXEC cycle of an iterative instruction with count=8 -> immediately IDLE, inst_ready=1, flags=000, no rf_wr_en pulse, next instruction executes normally.
- inst_valid held high with two back-to-back ADDs -> second accepted exactly one edge after the first done; no instruction is dropped or duplicated.
